// File: rtl/decode_stage_ctrl_if.sv
// ============================================================================
// Module      : decode_stage_ctrl_if
// Description : Bundle between the IF/ID side (instruction, valid and hazard
//               controls) and the registered ID/EX control outputs of
//               decode_stage_ctrl.
//               master : drives instr_i/valid_i/stall_i/flush_i, observes outputs
//               slave  : the decoder; consumes inputs, drives outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_stage_ctrl_if #(
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 16
);
  logic [31:0]           instr_i;
  logic                  valid_i;
  logic                  stall_i;
  logic                  flush_i;

  logic                  valid_o;
  logic [1:0]            flag_w_o;
  logic                  pcs_o;
  logic                  branch_o;
  logic                  reg_w_o;
  logic                  mem_w_o;
  logic                  mem_to_reg_o;
  logic                  alu_src_o;
  logic [1:0]            imm_src_o;
  logic [1:0]            reg_src_o;
  logic [ALU_CTRL_W-1:0] alu_control_o;
  logic                  illegal_o;
  logic                  illegal_seen_o;
  logic [CNT_W-1:0]      decoded_cnt_o;

  modport master (
    output instr_i, valid_i, stall_i, flush_i,
    input  valid_o, flag_w_o, pcs_o, branch_o, reg_w_o, mem_w_o,
           mem_to_reg_o, alu_src_o, imm_src_o, reg_src_o, alu_control_o,
           illegal_o, illegal_seen_o, decoded_cnt_o
  );

  modport slave (
    input  instr_i, valid_i, stall_i, flush_i,
    output valid_o, flag_w_o, pcs_o, branch_o, reg_w_o, mem_w_o,
           mem_to_reg_o, alu_src_o, imm_src_o, reg_src_o, alu_control_o,
           illegal_o, illegal_seen_o, decoded_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/decode_stage_ctrl.sv
// ============================================================================
// Module      : decode_stage_ctrl
// Description : Registered ID-stage decoder for the ARM-subset pipeline.
//               Decodes Op/Funct/Rd of the IF/ID instruction into control
//               signals and registers them into ID/EX with flush > stall >
//               load priority, flags undefined encodings and counts legal
//               instructions with a saturating counter.
// Ports       : clk, rst_n (synchronous, active-low)
//               bus (slave) : instr_i, valid_i, stall_i, flush_i in;
//                             registered controls, illegal_o,
//                             illegal_seen_o, decoded_cnt_o out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage_ctrl #(
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  decode_stage_ctrl_if.slave  bus
);

  // Control word layout, MSB first:
  // flag_w[1:0] pcs branch reg_w mem_w mem_to_reg alu_src
  // imm_src[1:0] reg_src[1:0] alu[2:0]
  localparam int CTRL_W = 15;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;

  assign op    = bus.instr_i[27:26];
  assign funct = bus.instr_i[25:20];
  assign cmd   = funct[4:1];
  assign rd    = bus.instr_i[15:12];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr_i[31:28], bus.instr_i[19:16],
                               bus.instr_i[11:0]};

  // Combinational decode
  logic [1:0] d_flag_w;
  logic       d_branch;
  logic       d_reg_w;
  logic       d_mem_w;
  logic       d_mem_to_reg;
  logic       d_alu_src;
  logic [1:0] d_imm_src;
  logic [1:0] d_reg_src;
  logic [2:0] d_alu;
  logic       d_illegal;
  logic       d_pcs;

  always_comb begin
    d_flag_w     = 2'b00;
    d_branch     = 1'b0;
    d_reg_w      = 1'b0;
    d_mem_w      = 1'b0;
    d_mem_to_reg = 1'b0;
    d_alu_src    = 1'b0;
    d_imm_src    = 2'b00;
    d_reg_src    = 2'b00;
    d_alu        = 3'b000;
    d_illegal    = 1'b0;

    case (op)
      2'b00: begin
        d_reg_w   = 1'b1;
        d_alu_src = funct[5];
        case (cmd)
          4'b0100: d_alu = 3'b000;            // ADD
          4'b0010: d_alu = 3'b001;            // SUB
          4'b0000: d_alu = 3'b010;            // AND
          4'b1100: d_alu = 3'b011;            // ORR
          4'b0001: d_alu = 3'b100;            // EOR
          4'b1101: d_alu = 3'b101;            // MOV
          4'b1010: begin                      // CMP: flags only, needs S
            d_alu     = 3'b001;
            d_reg_w   = 1'b0;
            d_illegal = ~funct[0];
          end
          default: d_illegal = 1'b1;
        endcase
        d_flag_w[1] = funct[0];
        d_flag_w[0] = funct[0] &
                      ((cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010));
      end
      2'b01: begin
        d_alu_src = 1'b1;
        d_imm_src = 2'b01;
        // U=1 adds the offset, U=0 subtracts it
        d_alu     = funct[3] ? 3'b000 : 3'b001;
        if (funct[0]) begin                   // LDR
          d_reg_w      = 1'b1;
          d_mem_to_reg = 1'b1;
        end else begin                        // STR reads Rd on RA2
          d_mem_w   = 1'b1;
          d_reg_src = 2'b10;
        end
      end
      2'b10: begin
        d_branch  = 1'b1;
        d_alu_src = 1'b1;
        d_imm_src = 2'b10;
        d_reg_src = 2'b01;
      end
      default: d_illegal = 1'b1;
    endcase

    // Undefined encodings must not write anything downstream
    if (d_illegal) begin
      d_flag_w     = 2'b00;
      d_branch     = 1'b0;
      d_reg_w      = 1'b0;
      d_mem_w      = 1'b0;
      d_mem_to_reg = 1'b0;
      d_alu_src    = 1'b0;
      d_imm_src    = 2'b00;
      d_reg_src    = 2'b00;
      d_alu        = 3'b000;
    end

    d_pcs = d_branch | (d_reg_w & (rd == 4'hF));
  end

  logic [CTRL_W-1:0] d_ctrl;
  assign d_ctrl = {d_flag_w, d_pcs, d_branch, d_reg_w, d_mem_w, d_mem_to_reg,
                   d_alu_src, d_imm_src, d_reg_src, d_alu};

  // ID/EX register
  logic              q_valid;
  logic [CTRL_W-1:0] q_ctrl;
  logic              q_illegal;
  logic              q_seen;
  logic [CNT_W-1:0]  q_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid   <= 1'b0;
      q_ctrl    <= '0;
      q_illegal <= 1'b0;
      q_seen    <= 1'b0;
      q_cnt     <= '0;
    end else if (bus.flush_i) begin
      q_valid   <= 1'b0;
      q_ctrl    <= '0;
      q_illegal <= 1'b0;
    end else if (!bus.stall_i) begin
      if (bus.valid_i) begin
        q_valid   <= 1'b1;
        q_ctrl    <= d_ctrl;
        q_illegal <= d_illegal;
        if (d_illegal) begin
          q_seen <= 1'b1;
        end else if (q_cnt != {CNT_W{1'b1}}) begin
          q_cnt <= q_cnt + 1'b1;
        end
      end else begin
        q_valid   <= 1'b0;
        q_ctrl    <= '0;
        q_illegal <= 1'b0;
      end
    end
  end

  assign bus.valid_o        = q_valid;
  assign bus.flag_w_o       = q_ctrl[14:13];
  assign bus.pcs_o          = q_ctrl[12];
  assign bus.branch_o       = q_ctrl[11];
  assign bus.reg_w_o        = q_ctrl[10];
  assign bus.mem_w_o        = q_ctrl[9];
  assign bus.mem_to_reg_o   = q_ctrl[8];
  assign bus.alu_src_o      = q_ctrl[7];
  assign bus.imm_src_o      = q_ctrl[6:5];
  assign bus.reg_src_o      = q_ctrl[4:3];
  assign bus.alu_control_o  = ALU_CTRL_W'(q_ctrl[2:0]);
  assign bus.illegal_o      = q_illegal;
  assign bus.illegal_seen_o = q_seen;
  assign bus.decoded_cnt_o  = q_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_ctrl.sv
// ============================================================================
// Module      : tb_decode_stage_ctrl
// Description : Self-checking bench for decode_stage_ctrl. Two instances
//               (CNT_W=16 and CNT_W=3) share the same stimulus; an
//               instruction-class model predicts outputs every cycle, and
//               literal checks pin selected results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_ctrl_if #(.ALU_CTRL_W(3), .CNT_W(16)) bus16 ();
  decode_stage_ctrl_if #(.ALU_CTRL_W(3), .CNT_W(3))  bus3  ();

  decode_stage_ctrl #(.ALU_CTRL_W(3), .CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16));
  decode_stage_ctrl #(.ALU_CTRL_W(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  logic [31:0] instr;
  logic        valid, stall, flush;

  assign bus16.instr_i = instr;
  assign bus16.valid_i = valid;
  assign bus16.stall_i = stall;
  assign bus16.flush_i = flush;
  assign bus3.instr_i  = instr;
  assign bus3.valid_i  = valid;
  assign bus3.stall_i  = stall;
  assign bus3.flush_i  = flush;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       valid;
    logic [1:0] flag_w;
    logic       pcs;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu;
    logic       illegal;
  } exp_t;

  typedef enum { K_ADD, K_SUB, K_AND, K_ORR, K_EOR, K_MOV, K_CMP,
                 K_LDR, K_STR, K_B, K_ILL } kind_e;

  // Classify an instruction into its mnemonic
  function automatic kind_e classify(input logic [31:0] ins);
    logic [1:0] op;
    logic [5:0] f;
    op = ins[27:26];
    f  = ins[25:20];
    if (op == 2'b01) return f[0] ? K_LDR : K_STR;
    if (op == 2'b10) return K_B;
    if (op == 2'b11) return K_ILL;
    case (f[4:1])
      4'd4:  return K_ADD;
      4'd2:  return K_SUB;
      4'd0:  return K_AND;
      4'd12: return K_ORR;
      4'd1:  return K_EOR;
      4'd13: return K_MOV;
      4'd10: return f[0] ? K_CMP : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  // Expected control for a valid instruction, built per mnemonic
  function automatic exp_t expect_for(input logic [31:0] ins);
    exp_t  e;
    kind_e k;
    logic  s, imm_bit;
    k       = classify(ins);
    s       = ins[20];
    imm_bit = ins[25];
    e       = '0;
    e.valid = 1'b1;
    case (k)
      K_ILL: e.illegal = 1'b1;
      K_LDR, K_STR: begin
        e.alu_src = 1'b1;
        e.imm_src = 2'b01;
        e.alu     = ins[23] ? 3'd0 : 3'd1;
        if (k == K_LDR) begin
          e.reg_w = 1'b1; e.mem_to_reg = 1'b1;
        end else begin
          e.mem_w = 1'b1; e.reg_src = 2'b10;
        end
      end
      K_B: begin
        e.branch = 1'b1; e.alu_src = 1'b1;
        e.imm_src = 2'b10; e.reg_src = 2'b01;
      end
      default: begin
        e.alu_src = imm_bit;
        e.reg_w   = (k != K_CMP);
        e.alu     = (k == K_ADD) ? 3'd0 : (k == K_SUB || k == K_CMP) ? 3'd1 :
                    (k == K_AND) ? 3'd2 : (k == K_ORR) ? 3'd3 :
                    (k == K_EOR) ? 3'd4 : 3'd5;
        e.flag_w  = {s, s && (k == K_ADD || k == K_SUB || k == K_CMP)};
      end
    endcase
    e.pcs = e.branch || (e.reg_w && ins[15:12] == 4'd15);
    return e;
  endfunction

  // Model state
  exp_t m_out;
  bit   m_seen;
  int   m_cnt;
  bit   m_ok = 1'b0;

  function automatic exp_t dut_out16();
    return {bus16.valid_o, bus16.flag_w_o, bus16.pcs_o, bus16.branch_o,
            bus16.reg_w_o, bus16.mem_w_o, bus16.mem_to_reg_o, bus16.alu_src_o,
            bus16.imm_src_o, bus16.reg_src_o, bus16.alu_control_o,
            bus16.illegal_o};
  endfunction

  function automatic exp_t dut_out3();
    return {bus3.valid_o, bus3.flag_w_o, bus3.pcs_o, bus3.branch_o,
            bus3.reg_w_o, bus3.mem_w_o, bus3.mem_to_reg_o, bus3.alu_src_o,
            bus3.imm_src_o, bus3.reg_src_o, bus3.alu_control_o,
            bus3.illegal_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Model update on each edge, then compare just after it
  always @(posedge clk) begin
    if (!rst_n) begin
      m_out  = '0;
      m_seen = 1'b0;
      m_cnt  = 0;
      m_ok   = 1'b1;
    end else if (flush) begin
      m_out  = '0;
    end else if (!stall) begin
      if (valid) begin
        m_out = expect_for(instr);
        if (m_out.illegal) m_seen = 1'b1;
        else               m_cnt  = m_cnt + 1;
      end else begin
        m_out = '0;
      end
    end
    #1;
    if (m_ok) begin
      chk("outs16", 32'(dut_out16()), 32'(m_out));
      chk("outs3",  32'(dut_out3()),  32'(m_out));
      chk("seen16", 32'(bus16.illegal_seen_o), 32'(m_seen));
      chk("seen3",  32'(bus3.illegal_seen_o),  32'(m_seen));
      chk("cnt16",  32'(bus16.decoded_cnt_o),  32'((m_cnt > 65535) ? 65535 : m_cnt));
      chk("cnt3",   32'(bus3.decoded_cnt_o),   32'((m_cnt > 7) ? 7 : m_cnt));
    end
  end

  task automatic step(input logic [31:0] ins, input logic v,
                      input logic st, input logic fl);
    @(negedge clk);
    instr = ins; valid = v; stall = st; flush = fl;
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] ADD  = 32'hE0821003;
  localparam logic [31:0] SUBS = 32'hE2523001;
  localparam logic [31:0] CMP  = 32'hE1500001;
  localparam logic [31:0] LDR  = 32'hE5912004;
  localparam logic [31:0] STR  = 32'hE5012004;
  localparam logic [31:0] BR   = 32'hEA000002;
  localparam logic [31:0] MOVP = 32'hE1A0F00E;
  localparam logic [31:0] OP11 = 32'hEC000000;
  localparam logic [31:0] CMP0 = 32'hE1400001;

  initial begin
    rst_n = 1'b0; instr = ADD; valid = 1'b1; stall = 1'b0; flush = 1'b0;

    // Reset for two edges
    step(ADD, 1, 0, 0);
    step(ADD, 1, 0, 0);
    chk("rst_valid", 32'(bus16.valid_o), 0);
    chk("rst_reg_w", 32'(bus16.reg_w_o), 0);
    chk("rst_cnt",   32'(bus16.decoded_cnt_o), 0);

    rst_n = 1'b1;
    step(ADD, 1, 0, 0);
    chk("add_valid", 32'(bus16.valid_o), 1);
    chk("add_reg_w", 32'(bus16.reg_w_o), 1);
    chk("add_alu",   32'(bus16.alu_control_o), 0);
    chk("add_flagw", 32'(bus16.flag_w_o), 0);
    chk("add_cnt",   32'(bus16.decoded_cnt_o), 1);

    // Decode sweep
    step(SUBS, 1, 0, 0);
    chk("subs_alu",  32'(bus16.alu_control_o), 1);
    chk("subs_src",  32'(bus16.alu_src_o), 1);
    chk("subs_flag", 32'(bus16.flag_w_o), 3);
    step(CMP, 1, 0, 0);
    chk("cmp_reg_w", 32'(bus16.reg_w_o), 0);
    chk("cmp_flag",  32'(bus16.flag_w_o), 3);
    step(LDR, 1, 0, 0);
    chk("ldr_m2r",   32'(bus16.mem_to_reg_o), 1);
    chk("ldr_imm",   32'(bus16.imm_src_o), 1);
    chk("ldr_alu",   32'(bus16.alu_control_o), 0);
    step(STR, 1, 0, 0);
    chk("str_mem_w", 32'(bus16.mem_w_o), 1);
    chk("str_alu",   32'(bus16.alu_control_o), 1);
    chk("str_rsrc",  32'(bus16.reg_src_o), 2);
    step(BR, 1, 0, 0);
    chk("b_branch",  32'(bus16.branch_o), 1);
    chk("b_pcs",     32'(bus16.pcs_o), 1);
    chk("b_imm",     32'(bus16.imm_src_o), 2);
    step(MOVP, 1, 0, 0);
    chk("mov_pcs",   32'(bus16.pcs_o), 1);
    chk("mov_alu",   32'(bus16.alu_control_o), 5);
    chk("sat_cnt3_7", 32'(bus3.decoded_cnt_o), 7);

    // Stall / flush
    step(ADD, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(SUBS, 1, 1, 0);
      chk("stall_alu", 32'(bus16.alu_control_o), 0);
      chk("stall_cnt", 32'(bus16.decoded_cnt_o), 8);
    end
    step(SUBS, 1, 1, 1);
    chk("flush_valid", 32'(bus16.valid_o), 0);
    chk("flush_reg_w", 32'(bus16.reg_w_o), 0);
    chk("flush_cnt",   32'(bus16.decoded_cnt_o), 8);

    // Illegal instructions
    step(OP11, 1, 0, 0);
    chk("ill11_ill",   32'(bus16.illegal_o), 1);
    chk("ill11_valid", 32'(bus16.valid_o), 1);
    chk("ill11_reg_w", 32'(bus16.reg_w_o), 0);
    chk("ill11_seen",  32'(bus16.illegal_seen_o), 1);
    step(CMP0, 1, 0, 0);
    chk("cmp0_ill",    32'(bus16.illegal_o), 1);
    chk("cmp0_flag",   32'(bus16.flag_w_o), 0);
    chk("cmp0_cnt",    32'(bus16.decoded_cnt_o), 8);
    step(ADD, 1, 0, 0);
    chk("post_ill",    32'(bus16.illegal_o), 0);
    chk("post_seen",   32'(bus16.illegal_seen_o), 1);
    chk("post_cnt",    32'(bus16.decoded_cnt_o), 9);

    // valid_i=0 gives a bubble
    step(ADD, 0, 0, 0);
    chk("bub_valid",   32'(bus16.valid_o), 0);
    chk("bub_reg_w",   32'(bus16.reg_w_o), 0);
    chk("bub_cnt",     32'(bus16.decoded_cnt_o), 9);

    step(ADD, 1, 0, 0);
    chk("sat_cnt16",   32'(bus16.decoded_cnt_o), 10);
    chk("sat_cnt3",    32'(bus3.decoded_cnt_o), 7);

    // Reset clears the sticky flag
    rst_n = 1'b0;
    step(ADD, 1, 0, 0);
    chk("rst2_seen",   32'(bus16.illegal_seen_o), 0);
    chk("rst2_cnt",    32'(bus16.decoded_cnt_o), 0);
    rst_n = 1'b1;
    step(ADD, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
